// File: rtl/elastic_pipe_stage_if.sv
// Valid/allow link between two pipeline stages. The producer (master) drives
// valid and data; the consumer (slave) drives allow. A transfer happens in a
// cycle where valid and allow are both high at the rising clock edge.
interface elastic_pipe_stage_if #(
  parameter int WIDTH = 100
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             allow;

  modport master (output valid, output data, input allow);
  modport slave  (input valid, input data, output allow);
endinterface

// File: rtl/elastic_pipe_stage.sv
// elastic_pipe_stage: DEPTH-entry elastic register between two pipeline stages.
// A circular buffer with a valid/allow interlock on both sides, a ready_go stall
// on the head entry, and a synchronous flush.
//   up_if : upstream link   (up_if.valid = valid_in,  up_if.data = data_in,  up_if.allow = allow_out)
//   dn_if : downstream link (dn_if.valid = valid_out, dn_if.data = data_out, dn_if.allow = allow_in)
// Handshake: a beat moves on a rising edge when valid and allow are both high;
// valid is never made to depend on allow on the same link, and a held beat
// keeps its data stable until accepted.
// DEPTH=1 behaves like a single inter-stage register: allow_out bypasses
// allow_in combinationally. DEPTH>=2 cuts that path; allow_out depends only
// on occupancy.
// Optional macro ELASTIC_STAGE_PERF_EN adds saturating stall/bubble counters.
module elastic_pipe_stage #(
  parameter int               WIDTH       = 100,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               IS_PC       = 1'b0
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  elastic_pipe_stage_if.slave        up_if,
  elastic_pipe_stage_if.master       dn_if,
  input  logic                       ready_go,
  input  logic [WIDTH-1:0]           nop_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef ELASTIC_STAGE_PERF_EN
  ,
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_bubble_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic not_empty;
  logic valid_out;
  logic allow_out;
  logic push;
  logic pop;

  // Handshake qualifiers; flush suppresses both transfers in its cycle.
  assign not_empty = (count_q != '0);
  assign valid_out = not_empty && ready_go;
  assign pop       = valid_out && dn_if.allow && !flush;
  assign push      = up_if.valid && allow_out && !flush;

  generate
    if (DEPTH == 1) begin : g_bypass_allow
      // Single entry: accept when empty or when the held entry leaves this cycle.
      assign allow_out = !not_empty || (valid_out && dn_if.allow);
    end else begin : g_occupancy_allow
      // Multi entry: accept whenever a slot is free, independent of downstream.
      assign allow_out = (count_q < CNT_W'(DEPTH));
    end
  endgenerate

  // Next pointer/occupancy state; pointers wrap at DEPTH-1 for any DEPTH.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; reset and flush restore every entry to RESET_VALUE.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VALUE;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VALUE;
    end else if (push) begin
      mem_q[wr_ptr_q] <= up_if.data;
    end
  end

  // Output side: head entry, or nop_data while empty unless the stage carries a PC.
  always_comb begin
    dn_if.data = mem_q[rd_ptr_q];
    if (!not_empty && !IS_PC) dn_if.data = nop_data;
  end

  assign dn_if.valid = valid_out;
  assign up_if.allow = allow_out;
  assign count       = count_q;

`ifdef ELASTIC_STAGE_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_bubble_q;

  // Saturating stall/bubble counters; only reset clears them.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      perf_stall_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      if (not_empty && !pop && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (!not_empty && (perf_bubble_q != 32'hFFFF_FFFF)) begin
        perf_bubble_q <= perf_bubble_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt  = perf_stall_q;
  assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule
